// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready handshake on both sides.
//
// ADD, SUB, AND, OR, XOR and SLT finish in the accept cycle. SLL and SRL
// shift one bit per clock, so they take shamt+1 cycles. With the macro
// ALU_MUL_EN defined, MUL runs a shift-add multiply over WIDTH cycles.
// Without ALU_MUL_EN, MUL behaves like any unused opcode: result 0, ZF=1, SF=0.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     operation offered
//   in_ready     block can accept (IDLE only)
//   SrcA, SrcB   operands, WIDTH bits
//   ALUControl   opcode (4 bits)
//   out_valid    ALUResult/ZF/SF valid (DONE only)
//   out_ready    consumer takes the result
//   ALUResult    result, WIDTH bits
//   ZF, SF       zero flag, sign / signed-less-than flag
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             ZF,
    output logic             SF
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, MUL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [3:0]       opc;
    logic [CW-1:0]    cnt;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] prodNext;
`endif

    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic             lt;
    logic [WIDTH-1:0] qres;
    logic             qsf;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] shiftNext;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign shamt     = SrcB[SW-1:0];

    // Single-cycle result and flags, computed straight from the inputs so
    // they can be captured on the accept edge. The signed less-than is the
    // difference MSB corrected by the overflow of A-B; this drives SLT and
    // also SF for SUB and SLT. A zero shamt leaves SLL/SRL equal to SrcA.
    always_comb begin
        diff = SrcA - SrcB;
        ovf  = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
        lt   = diff[WIDTH-1] ^ ovf;
        qres = '0;
        case (ALUControl)
            OP_ADD:  qres = SrcA + SrcB;
            OP_SUB:  qres = diff;
            OP_AND:  qres = SrcA & SrcB;
            OP_OR:   qres = SrcA | SrcB;
            OP_XOR:  qres = SrcA ^ SrcB;
            OP_SLL:  qres = SrcA;
            OP_SRL:  qres = SrcA;
            OP_SLT:  qres = {{(WIDTH-1){1'b0}}, lt};
            default: qres = '0;
        endcase
        qsf = ((ALUControl == OP_SUB) || (ALUControl == OP_SLT)) ? lt : qres[WIDTH-1];
    end

    // One bit of shifting per cycle on the captured operand. SRL zero-fills.
    always_comb begin
        shiftNext = (opc == OP_SRL) ? (opa >> 1) : (opa << 1);
    end

`ifdef ALU_MUL_EN
    // Shift-add step. The multiplier LSB decides whether the shifted
    // multiplicand is added in this cycle.
    always_comb begin
        prodNext = prod + (opb[0] ? opa : '0);
    end
`endif

    // Main control FSM. The result registers load only on entry to DONE, so
    // they hold steady through back-pressure and through SHIFT/MUL. DONE
    // always returns to IDLE before the next accept, which leaves one idle
    // cycle between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            opa       <= '0;
            opc       <= '0;
            cnt       <= '0;
            ALUResult <= '0;
            ZF        <= 1'b0;
            SF        <= 1'b0;
`ifdef ALU_MUL_EN
            opb       <= '0;
            prod      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa <= SrcA;
                        opc <= ALUControl;
                        cnt <= '0;
                        if (((ALUControl == OP_SLL) || (ALUControl == OP_SRL)) && (shamt != '0)) begin
                            state <= SHIFT;
                            cnt   <= {1'b0, shamt};
                        end
`ifdef ALU_MUL_EN
                        else if (ALUControl == OP_MUL) begin
                            state <= MUL;
                            opb   <= SrcB;
                            prod  <= '0;
                            cnt   <= CW'(WIDTH);
                        end
`endif
                        else begin
                            state     <= DONE;
                            ALUResult <= qres;
                            ZF        <= (qres == '0);
                            SF        <= qsf;
                        end
                    end
                end
                SHIFT: begin
                    opa <= shiftNext;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        ALUResult <= shiftNext;
                        ZF        <= (shiftNext == '0);
                        SF        <= shiftNext[WIDTH-1];
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    prod <= prodNext;
                    opa  <= opa << 1;
                    opb  <= opb >> 1;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        ALUResult <= prodNext;
                        ZF        <= (prodNext == '0);
                        SF        <= prodNext[WIDTH-1];
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven bench for alu_seq at WIDTH=32.
// Expected values for MUL follow ALU_MUL_EN so the bench matches either build.
module tb_alu_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             ZF;
    logic             SF;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        logic        expZf;
        logic        expSf;
        int          expLat;
    } vector_t;

    vector_t vectors[$];

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .ZF         (ZF),
        .SF         (SF)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic z, input logic s, input int lat);
        vector_t v;
        v.name   = n;
        v.op     = op;
        v.a      = a;
        v.b      = b;
        v.expRes = r;
        v.expZf  = z;
        v.expSf  = s;
        v.expLat = lat;
        vectors.push_back(v);
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] res, output logic zf, output logic sf);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        tick();
        in_valid   = 1'b0;
        SrcA       = $urandom;
        SrcB       = $urandom;
        ALUControl = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        res = ALUResult;
        zf  = ZF;
        sf  = SF;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        zf;
        logic        sf;
        bit          seen;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = '0;
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ALUResult", ALUResult, 32'd0);
        checkOutput("rst_ZF", 32'(ZF), 32'd0);
        checkOutput("rst_SF", 32'(SF), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        addVec("sub_eq",      4'b0001, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1);
        addVec("sub_min",     4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
        addVec("slt_min",     4'b0111, 32'h80000000, 32'h00000001, 32'd1,        1'b0, 1'b1, 1);
        addVec("sub_ovf",     4'b0001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1);
        addVec("sub_neg",     4'b0001, 32'd3,        32'd7,        32'hFFFFFFFC, 1'b0, 1'b1, 1);
        addVec("slt_false",   4'b0111, 32'd3,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1);
        addVec("slt_true",    4'b0111, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0, 1'b1, 1);
        addVec("add_wrap",    4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1);
        addVec("add_msb",     4'b0000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1);
        addVec("and",         4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1);
        addVec("or",          4'b0011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1);
        addVec("xor",         4'b0100, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0, 1);
        addVec("sll_31",      4'b0101, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b1, 32);
        addVec("sll_1",       4'b0101, 32'h00000003, 32'd1,        32'h00000006, 1'b0, 1'b0, 2);
        addVec("srl_0",       4'b0110, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1);
        addVec("srl_4",       4'b0110, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 5);
        addVec("srl_31",      4'b0110, 32'hFFFFFFFF, 32'd31,       32'h00000001, 1'b0, 1'b0, 32);
        addVec("unused_op",   4'b1111, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1);
`ifdef ALU_MUL_EN
        addVec("mul_7x6",     4'b1000, 32'd7,        32'd6,        32'd42,       1'b0, 1'b0, 33);
`else
        addVec("mul_7x6",     4'b1000, 32'd7,        32'd6,        32'd0,        1'b1, 1'b0, 1);
`endif

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].name, vectors[i].op, vectors[i].a, vectors[i].b, lat, res, zf, sf);
            checkOutput({vectors[i].name, "_result"}, res, vectors[i].expRes);
            checkOutput({vectors[i].name, "_ZF"}, 32'(zf), 32'(vectors[i].expZf));
            checkOutput({vectors[i].name, "_SF"}, 32'(sf), 32'(vectors[i].expSf));
            checkOutput({vectors[i].name, "_latency"}, 32'(lat), 32'(vectors[i].expLat));
        end

        in_valid   = 1'b1;
        ALUControl = 4'b0000;
        SrcA       = 32'd2;
        SrcB       = 32'd3;
        tick();
        SrcA = 32'd10;
        SrcB = 32'd20;
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_result", ALUResult, 32'd5);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_hold_result", ALUResult, 32'd5);
            checkOutput("bp_hold_ZF", 32'(ZF), 32'd0);
            checkOutput("bp_hold_SF", 32'(SF), 32'd0);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_next_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_next_result", ALUResult, 32'd30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        in_valid   = 1'b1;
        ALUControl = 4'b0101;
        SrcA       = 32'd1;
        SrcB       = 32'd20;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checkOutput("abort_busy_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy_result_held", ALUResult, 32'd30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_result", ALUResult, 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checkOutput("abort_no_delivery", 32'(seen), 32'd0);

        rst        = 1'b1;
        in_valid   = 1'b1;
        ALUControl = 4'b0000;
        SrcA       = 32'd1;
        SrcB       = 32'd1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_prio_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_prio_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
